// File: rtl/mem_responder_pkg.sv
// Shared encodings for the CPU memory request path: size codes and responder states.
package mem_responder_pkg;

    // Request size codes, shared with the CPU control path
    typedef enum logic [1:0] {
        MSZ_NONE = 2'b00,
        MSZ_1    = 2'b01,
        MSZ_4    = 2'b10,
        MSZ_8    = 2'b11
    } msz_e;

    // Responder states
    typedef enum logic [1:0] {
        MR_IDLE  = 2'b00,
        MR_WRITE = 2'b01,
        MR_READ  = 2'b10,
        MR_ACK   = 2'b11
    } mr_state_e;

    // Byte count for a size code (0 for MSZ_NONE)
    function automatic logic [3:0] msz_bytes(input logic [1:0] sz);
        logic [3:0] n;
        case (sz)
            MSZ_1:   n = 4'd1;
            MSZ_4:   n = 4'd4;
            MSZ_8:   n = 4'd8;
            default: n = 4'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/mem_responder.sv
// Byte-serialising RAM responder: turns one 1/4/8-byte request into byte
// accesses on a synchronous byte RAM and returns little-endian read data.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// MR_IDLE  | waiting for a request; req sampled only here
// MR_WRITE | one RAM write per cycle, byte idx of latched write data
// MR_READ  | addresses issued for idx < N, byte idx-1 captured from ram_q
// MR_ACK   | one-cycle completion pulse, then back to idle
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int AW = 16,
    parameter int DW = 64
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_req,
    input  logic          i_we,
    input  logic [1:0]    i_size,
    input  logic [AW-1:0] i_addr,
    input  logic [DW-1:0] i_wdata,
    output logic          o_busy,
    output logic          o_ack,
    output logic [DW-1:0] o_rdata,
    output logic [AW-1:0] o_ram_addr,
    output logic          o_ram_we,
    output logic [7:0]    o_ram_d,
    input  logic [7:0]    i_ram_q
);

    localparam int NB = DW / 8;

    mr_state_e     r_state;
    mr_state_e     w_state_nxt;
    logic [AW-1:0] r_base;
    logic [1:0]    r_size;
    logic [3:0]    r_idx;
    logic [DW-1:0] r_wbuf;
    logic [DW-1:0] r_rbuf;

    logic [3:0]    w_n;
    logic [3:0]    w_n_req;
    logic [3:0]    w_rd_idx;
    logic [DW-1:0] w_keep;

    assign w_n     = msz_bytes(r_size);
    assign w_n_req = msz_bytes(i_size);
    // During the final read cycle the address holds on the last byte
    assign w_rd_idx = (r_idx == w_n) ? (r_idx - 4'd1) : r_idx;
    assign o_rdata  = r_rbuf;

    // Byte mask of read bytes a new read keeps; bytes beyond its size are zero-extended
    always_comb begin
        w_keep = '0;
        for (int b = 0; b < NB; b++) begin
            if (b < int'(w_n_req)) begin
                w_keep[b*8 +: 8] = 8'hFF;
            end
        end
    end

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= MR_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and RAM port drive; outputs are decoded from state so reset drops them at once
    always_comb begin
        w_state_nxt = r_state;
        o_busy      = (r_state != MR_IDLE);
        o_ack       = 1'b0;
        o_ram_we    = 1'b0;
        o_ram_addr  = '0;
        o_ram_d     = '0;
        case (r_state)
            MR_IDLE: begin
                if (i_req) begin
                    if (i_size == MSZ_NONE) begin
                        w_state_nxt = MR_ACK;
                    end else if (i_we) begin
                        w_state_nxt = MR_WRITE;
                    end else begin
                        w_state_nxt = MR_READ;
                    end
                end
            end
            MR_WRITE: begin
                o_ram_we   = 1'b1;
                o_ram_addr = r_base + AW'(r_idx);
                o_ram_d    = r_wbuf[r_idx*8 +: 8];
                if (r_idx == w_n - 4'd1) begin
                    w_state_nxt = MR_ACK;
                end
            end
            MR_READ: begin
                o_ram_addr = r_base + AW'(w_rd_idx);
                if (r_idx == w_n) begin
                    w_state_nxt = MR_ACK;
                end
            end
            MR_ACK: begin
                o_ack       = 1'b1;
                w_state_nxt = MR_IDLE;
            end
            default: w_state_nxt = MR_IDLE;
        endcase
    end

    // Request latch, byte index and read-data assembly
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_base <= '0;
            r_size <= '0;
            r_idx  <= '0;
            r_wbuf <= '0;
            r_rbuf <= '0;
        end else begin
            case (r_state)
                MR_IDLE: begin
                    if (i_req) begin
                        r_base <= i_addr;
                        r_size <= i_size;
                        r_wbuf <= i_wdata;
                        r_idx  <= '0;
                        if (!i_we && (i_size != MSZ_NONE)) begin
                            r_rbuf <= r_rbuf & w_keep;
                        end
                    end
                end
                MR_WRITE: begin
                    r_idx <= r_idx + 4'd1;
                end
                MR_READ: begin
                    if (r_idx != 4'd0) begin
                        r_rbuf[(int'(r_idx) - 1)*8 +: 8] <= i_ram_q;
                    end
                    r_idx <= r_idx + 4'd1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: synchronous byte RAM model plus a
// shadow byte array as the reference memory, directed cases then random ones.
module tb_mem_responder;
    import mem_responder_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic [15:0] addr;
    logic [63:0] wdata;
    logic        o_busy;
    logic        o_ack;
    logic [63:0] o_rdata;
    logic [15:0] o_ram_addr;
    logic        o_ram_we;
    logic [7:0]  o_ram_d;
    logic [7:0]  ram_q;

    logic [7:0]  ram    [0:65535];
    logic [7:0]  shadow [0:65535];
    logic [63:0] exp_rdata;

    int n_checks = 0;
    int n_pass   = 0;

    mem_responder #(.AW(16), .DW(64)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_req      (req),
        .i_we       (we),
        .i_size     (size),
        .i_addr     (addr),
        .i_wdata    (wdata),
        .o_busy     (o_busy),
        .o_ack      (o_ack),
        .o_rdata    (o_rdata),
        .o_ram_addr (o_ram_addr),
        .o_ram_we   (o_ram_we),
        .o_ram_d    (o_ram_d),
        .i_ram_q    (ram_q)
    );

    always #5 clk = ~clk;

    // Byte RAM with one-cycle read latency
    always @(posedge clk) begin
        if (o_ram_we) ram[o_ram_addr] <= o_ram_d;
        ram_q <= ram[o_ram_addr];
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic int nbytes(input logic [1:0] s);
        case (s)
            2'b01:   return 1;
            2'b10:   return 4;
            2'b11:   return 8;
            default: return 0;
        endcase
    endfunction

    // One request, called at a negedge while idle. With hold=1, req stays high
    // through the transfer and the request fields are changed mid-transfer.
    task automatic do_txn(input logic t_we, input logic [1:0] t_size,
                          input logic [15:0] t_addr, input logic [63:0] t_wdata,
                          input bit hold);
        int          n;
        int          exp_ack;
        logic [15:0] a;
        n       = nbytes(t_size);
        exp_ack = (n == 0) ? 1 : (t_we ? n + 1 : n + 2);
        req   = 1'b1;
        we    = t_we;
        size  = t_size;
        addr  = t_addr;
        wdata = t_wdata;
        @(posedge clk);
        for (int k = 1; k <= exp_ack; k++) begin
            @(negedge clk);
            if (!hold) begin
                req = 1'b0;
            end else if (k == 2) begin
                we    = ~t_we;
                size  = 2'b11;
                addr  = t_addr + 16'h0040;
                wdata = ~t_wdata;
            end
            chk("busy", o_busy, 1'b1);
            chk("ack", o_ack, k == exp_ack);
            chk("ram_we", o_ram_we, t_we && (k <= n));
            if (k <= n) begin
                a = t_addr + 16'(k - 1);
                chk("ram_addr", o_ram_addr, a);
                if (t_we) chk("ram_d", o_ram_d, t_wdata[(k-1)*8 +: 8]);
            end else if (!t_we && n > 0 && k == n + 1) begin
                a = t_addr + 16'(n - 1);
                chk("ram_addr_hold", o_ram_addr, a);
            end
        end
        req = 1'b0;
        if (n > 0) begin
            if (t_we) begin
                for (int i = 0; i < n; i++) shadow[t_addr + 16'(i)] = t_wdata[i*8 +: 8];
            end else begin
                exp_rdata = '0;
                for (int i = 0; i < n; i++) exp_rdata[i*8 +: 8] = shadow[t_addr + 16'(i)];
            end
        end
        chk("rdata_ack", o_rdata, exp_rdata);
        @(negedge clk);
        chk("idle_busy", o_busy, 1'b0);
        chk("idle_ack", o_ack, 1'b0);
        chk("rdata_stable", o_rdata, exp_rdata);
        if (hold) begin
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                chk("hold_no_reaccept", {o_busy, o_ack}, 2'b00);
            end
        end
    endtask

    initial begin
        logic [7:0]  b;
        logic [15:0] ra;
        logic [63:0] rd;
        for (int i = 0; i < 65536; i++) begin
            b = 8'($urandom);
            ram[i]    = b;
            shadow[i] = b;
        end
        ram_q = '0;
        req = 1'b0; we = 1'b0; size = 2'b00; addr = '0; wdata = '0;
        exp_rdata = '0;
        rst_n = 1'b0;
        #12;
        chk("rst_busy", o_busy, 1'b0);
        chk("rst_ack", o_ack, 1'b0);
        chk("rst_ram_we", o_ram_we, 1'b0);
        chk("rst_ram_addr", o_ram_addr, 16'h0000);
        chk("rst_ram_d", o_ram_d, 8'h00);
        chk("rst_rdata", o_rdata, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed plan cases
        do_txn(1'b1, 2'b11, 16'h0100, 64'h8877665544332211, 1'b0);
        do_txn(1'b0, 2'b11, 16'h0100, 64'h0, 1'b0);
        chk("plan_rd8", o_rdata, 64'h8877665544332211);
        do_txn(1'b0, 2'b01, 16'h0103, 64'h0, 1'b0);
        chk("plan_rd1", o_rdata, 64'h0000000000000044);
        do_txn(1'b0, 2'b10, 16'h0104, 64'h0, 1'b0);
        chk("plan_rd4", o_rdata, 64'h0000000088776655);
        do_txn(1'b1, 2'b10, 16'hFFFE, 64'h00000000DDCCBBAA, 1'b0);
        chk("wrap_ram_fffe", ram[16'hFFFE], 8'hAA);
        chk("wrap_ram_0001", ram[16'h0001], 8'hDD);
        do_txn(1'b0, 2'b10, 16'hFFFE, 64'h0, 1'b0);
        chk("plan_wrap_rd", o_rdata, 64'h00000000DDCCBBAA);

        // Size none: no RAM access, rdata unchanged
        do_txn(1'b0, 2'b00, 16'h1234, 64'h0, 1'b0);
        do_txn(1'b1, 2'b00, 16'h1234, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        chk("none_rdata", o_rdata, 64'h00000000DDCCBBAA);

        // req held high with conflicting fields mid-transfer
        do_txn(1'b1, 2'b10, 16'h0300, 64'h00000000A1B2C3D4, 1'b1);
        do_txn(1'b0, 2'b11, 16'h0300, 64'h0, 1'b1);

        // Reset during an 8-byte write after three bytes
        req = 1'b1; we = 1'b1; size = 2'b11; addr = 16'h0200;
        wdata = 64'h0807060504030201;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_ram_we", o_ram_we, 1'b0);
        chk("mid_rst_busy", o_busy, 1'b0);
        chk("mid_rst_ack", o_ack, 1'b0);
        chk("mid_rst_rdata", o_rdata, 64'h0);
        for (int i = 0; i < 3; i++) shadow[16'h0200 + 16'(i)] = wdata[i*8 +: 8];
        exp_rdata = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_txn(1'b0, 2'b11, 16'h0200, 64'h0, 1'b0);

        // Random requests against the shadow memory
        for (int t = 0; t < 40; t++) begin
            ra = ($urandom_range(0, 3) == 0) ? (16'hFFF8 + 16'($urandom_range(0, 7)))
                                             : 16'($urandom);
            rd = {$urandom, $urandom};
            do_txn(1'($urandom), 2'($urandom), ra, rd, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
